traffic_sensor_conditioner: RTL and testbench

- Producer side of the traffic_light_fsm sensor interface.
- Takes raw, asynchronous loop-detector inputs for the four approaches (NS1, NS2, EW1, EW2) and drives the FSM's S1_* presence and S5_* congestion inputs.
- Per lane, it synchronizes the inputs, debounces them, and applies dwell/hysteresis qualification so the FSM sees only clean, stable requests.
- Sits between the detector pins and traffic_light_fsm; consumes the FSM's light_signal for stuck-detector supervision.

---
 rtl/traffic_sensor_conditioner_pkg.sv | 17 +
 rtl/traffic_sensor_conditioner_if.sv | 25 ++
 rtl/traffic_sensor_conditioner_lane_sensor_cond.sv | 122 ++++++++++++
 rtl/traffic_sensor_conditioner.sv | 45 ++++
 tb/tb_traffic_sensor_conditioner.sv | 151 +++++++++++++++
 5 files changed

// File: rtl/traffic_sensor_conditioner_pkg.sv
// Shared lane indices and S5 qualification state encoding for the sensor conditioner.
package traffic_sensor_pkg;

  localparam int LANE_NS1 = 3;
  localparam int LANE_NS2 = 2;
  localparam int LANE_EW1 = 1;
  localparam int LANE_EW2 = 0;

  // Bit 1 of the encoding is the congestion output itself.
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PENDING   = 2'd1,
    CONGESTED = 2'd2,
    CLEARING  = 2'd3
  } s5_state_e;

endpackage

// File: rtl/traffic_sensor_conditioner_if.sv
// Detector/light inputs and qualified S1/S5/stuck outputs between the pins, the FSM and the conditioner.
interface traffic_sensor_conditioner_if;

  logic [3:0] det1_raw;
  logic [3:0] det5_raw;
  logic [3:0] light_signal;
  logic       S1_NS1, S1_NS2, S1_EW1, S1_EW2;
  logic       S5_NS1, S5_NS2, S5_EW1, S5_EW2;
  logic [3:0] stuck_flag;

  modport master (
    output det1_raw, det5_raw, light_signal,
    input  S1_NS1, S1_NS2, S1_EW1, S1_EW2,
    input  S5_NS1, S5_NS2, S5_EW1, S5_EW2,
    input  stuck_flag
  );

  modport slave (
    input  det1_raw, det5_raw, light_signal,
    output S1_NS1, S1_NS2, S1_EW1, S1_EW2,
    output S5_NS1, S5_NS2, S5_EW1, S5_EW2,
    output stuck_flag
  );

endinterface

// File: rtl/traffic_sensor_conditioner_lane_sensor_cond.sv
// One lane: 2-flop sync and debounce of det1/det5, S5 dwell/hysteresis FSM, optional stuck supervision.
// Stuck supervision is built only when STUCK_DETECT_EN is defined.
module lane_sensor_cond
  import traffic_sensor_pkg::*;
#(
  parameter int DEB_CYCLES   = 4,
  parameter int CONG_CYCLES  = 50,
  parameter int CLEAR_CYCLES = 20,
  parameter int STUCK_CYCLES = 1000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_det1_raw,
  input  logic i_det5_raw,
  input  logic i_green,
  output logic o_s1,
  output logic o_s5,
  output logic o_stuck
);

  localparam int DW    = $clog2(DEB_CYCLES + 1);
  localparam int DWELL = (CONG_CYCLES > CLEAR_CYCLES) ? CONG_CYCLES : CLEAR_CYCLES;
  localparam int CW    = $clog2(DWELL + 1);

  // index 0 = det1, index 1 = det5
  logic [1:0]    r_sync1, r_sync2, r_db;
  logic [DW-1:0] r_deb_cnt [2];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_db    <= '0;
      for (int b = 0; b < 2; b++) r_deb_cnt[b] <= '0;
    end else begin
      r_sync1 <= {i_det5_raw, i_det1_raw};
      r_sync2 <= r_sync1;
      for (int b = 0; b < 2; b++) begin
        if (r_sync2[b] == r_db[b]) begin
          r_deb_cnt[b] <= '0;
        end else if (r_deb_cnt[b] >= DW'(DEB_CYCLES - 1)) begin
          r_db[b]      <= ~r_db[b];
          r_deb_cnt[b] <= '0;
        end else begin
          r_deb_cnt[b] <= r_deb_cnt[b] + 1'b1;
        end
      end
    end
  end

  s5_state_e     r_state, w_next_state;
  logic [CW-1:0] r_dwell, w_next_dwell, w_dwell_inc;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_dwell <= '0;
    end else begin
      r_state <= w_next_state;
      r_dwell <= w_next_dwell;
    end
  end

  // A det5 level change always takes priority over dwell completion.
  always_comb begin
    w_next_state = r_state;
    w_next_dwell = r_dwell;
    w_dwell_inc  = (r_dwell == '1) ? r_dwell : r_dwell + 1'b1;
    case (r_state)
      IDLE: if (r_db[1]) begin
        w_next_dwell = '0;
        w_next_state = (CONG_CYCLES == 1) ? CONGESTED : PENDING;
      end
      PENDING: begin
        if (!r_db[1])                               w_next_state = IDLE;
        else if (w_dwell_inc >= CW'(CONG_CYCLES - 1)) w_next_state = CONGESTED;
        else                                        w_next_dwell = w_dwell_inc;
      end
      CONGESTED: if (!r_db[1]) begin
        w_next_dwell = '0;
        w_next_state = (CLEAR_CYCLES == 1) ? IDLE : CLEARING;
      end
      CLEARING: begin
        if (r_db[1])                                   w_next_state = CONGESTED;
        else if (w_dwell_inc >= CW'(CLEAR_CYCLES - 1)) w_next_state = IDLE;
        else                                           w_next_dwell = w_dwell_inc;
      end
      default: w_next_state = IDLE;
    endcase
  end

  assign o_s5 = r_state[1];

`ifdef STUCK_DETECT_EN
  localparam int SW = $clog2(STUCK_CYCLES + 1);

  logic [SW-1:0] r_stuck_cnt;
  logic          r_stuck;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_stuck_cnt <= '0;
      r_stuck     <= 1'b0;
    end else if (i_green && r_db[0]) begin
      if (r_stuck_cnt >= SW'(STUCK_CYCLES - 1)) r_stuck <= 1'b1;
      if (r_stuck_cnt != SW'(STUCK_CYCLES))    r_stuck_cnt <= r_stuck_cnt + 1'b1;
    end else begin
      r_stuck_cnt <= '0;
    end
  end

  // A stuck lane keeps requesting service so it can never be starved.
  assign o_s1    = r_db[0] | r_stuck;
  assign o_stuck = r_stuck;
`else
  logic w_unused_green;
  assign w_unused_green = i_green ^ (STUCK_CYCLES > 0);
  assign o_s1    = r_db[0];
  assign o_stuck = 1'b0;
`endif

endmodule

// File: rtl/traffic_sensor_conditioner.sv
// Four-lane detector conditioner feeding traffic_light_fsm; optional stuck supervision via STUCK_DETECT_EN.
module traffic_sensor_conditioner
  import traffic_sensor_pkg::*;
#(
  parameter int DEB_CYCLES   = 4,
  parameter int CONG_CYCLES  = 50,
  parameter int CLEAR_CYCLES = 20,
  parameter int STUCK_CYCLES = 1000
) (
  input  logic                          clk,
  input  logic                          rst,
  traffic_sensor_conditioner_if.slave   sens
);

  logic [3:0] w_s1, w_s5, w_stuck;

  for (genvar i = 0; i < 4; i++) begin : g_lane
    lane_sensor_cond #(
      .DEB_CYCLES  (DEB_CYCLES),
      .CONG_CYCLES (CONG_CYCLES),
      .CLEAR_CYCLES(CLEAR_CYCLES),
      .STUCK_CYCLES(STUCK_CYCLES)
    ) u_lane (
      .i_clk     (clk),
      .i_rst     (rst),
      .i_det1_raw(sens.det1_raw[i]),
      .i_det5_raw(sens.det5_raw[i]),
      .i_green   (sens.light_signal[i]),
      .o_s1      (w_s1[i]),
      .o_s5      (w_s5[i]),
      .o_stuck   (w_stuck[i])
    );
  end

  assign sens.S1_NS1     = w_s1[LANE_NS1];
  assign sens.S1_NS2     = w_s1[LANE_NS2];
  assign sens.S1_EW1     = w_s1[LANE_EW1];
  assign sens.S1_EW2     = w_s1[LANE_EW2];
  assign sens.S5_NS1     = w_s5[LANE_NS1];
  assign sens.S5_NS2     = w_s5[LANE_NS2];
  assign sens.S5_EW1     = w_s5[LANE_EW1];
  assign sens.S5_EW2     = w_s5[LANE_EW2];
  assign sens.stuck_flag = w_stuck;

endmodule

// File: tb/tb_traffic_sensor_conditioner.sv
// Directed table-driven bench for traffic_sensor_conditioner with DEB=4, CONG=8, CLEAR=6, STUCK=32.
module tb_traffic_sensor_conditioner;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  traffic_sensor_conditioner_if sif ();

  traffic_sensor_conditioner #(
    .DEB_CYCLES  (4),
    .CONG_CYCLES (8),
    .CLEAR_CYCLES(6),
    .STUCK_CYCLES(32)
  ) dut (
    .clk (clk),
    .rst (rst),
    .sens(sif)
  );

  logic [3:0] w_s1, w_s5;
  assign w_s1 = {sif.S1_NS1, sif.S1_NS2, sif.S1_EW1, sif.S1_EW2};
  assign w_s5 = {sif.S5_NS1, sif.S5_NS2, sif.S5_EW1, sif.S5_EW2};

  typedef struct {
    string      name;
    logic       rst;
    logic [3:0] d1, d5, lt;
    int         n;
    logic [3:0] s1, s5, st;
  } vec_t;

  vec_t vq[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic add(input string nm, input logic r, input logic [3:0] d1, d5, lt,
                     input int n, input logic [3:0] s1, s5, st);
    vec_t v;
    v.name = nm; v.rst = r; v.d1 = d1; v.d5 = d5; v.lt = lt;
    v.n = n; v.s1 = s1; v.s5 = s5; v.st = st;
    vq.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [3:0] got, input logic [3:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", nm, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic [3:0] d1, d5, lt);
    rst = r;
    sif.det1_raw = d1;
    sif.det5_raw = d5;
    sif.light_signal = lt;
  endtask

  initial begin
    drive(1'b1, 4'b0, 4'b0, 4'b0);

    add("reset",        1, 4'h0, 4'h0, 4'h0,  2, 4'h0, 4'h0, 4'h0);
    add("s1_rise_m1",   0, 4'h8, 4'h0, 4'h0,  5, 4'h0, 4'h0, 4'h0);
    add("s1_rise",      0, 4'h8, 4'h0, 4'h0,  1, 4'h8, 4'h0, 4'h0);
    add("s1_hold",      0, 4'h8, 4'h0, 4'h0, 14, 4'h8, 4'h0, 4'h0);
    add("s1_fall_m1",   0, 4'h0, 4'h0, 4'h0,  5, 4'h8, 4'h0, 4'h0);
    add("s1_fall",      0, 4'h0, 4'h0, 4'h0,  1, 4'h0, 4'h0, 4'h0);
    add("glitch_a",     0, 4'h2, 4'h0, 4'h0,  3, 4'h0, 4'h0, 4'h0);
    add("glitch_b",     0, 4'h0, 4'h0, 4'h0,  3, 4'h0, 4'h0, 4'h0);
    add("glitch_c",     0, 4'h0, 4'h0, 4'h0,  7, 4'h0, 4'h0, 4'h0);
    add("two_lanes",    0, 4'h5, 4'h0, 4'h0,  6, 4'h5, 4'h0, 4'h0);
    add("two_lanes_off",0, 4'h0, 4'h0, 4'h0,  6, 4'h0, 4'h0, 4'h0);
    add("s5_rise_m1",   0, 4'h0, 4'h4, 4'h0, 13, 4'h0, 4'h0, 4'h0);
    add("s5_rise",      0, 4'h0, 4'h4, 4'h0,  1, 4'h0, 4'h4, 4'h0);
    add("s5_hold",      0, 4'h0, 4'h4, 4'h0, 10, 4'h0, 4'h4, 4'h0);
    add("s5_fall_m1",   0, 4'h0, 4'h0, 4'h0, 11, 4'h0, 4'h4, 4'h0);
    add("s5_fall",      0, 4'h0, 4'h0, 4'h0,  1, 4'h0, 4'h0, 4'h0);
    add("tie8_high",    0, 4'h0, 4'h1, 4'h0,  8, 4'h0, 4'h0, 4'h0);
    add("tie8_m1",      0, 4'h0, 4'h0, 4'h0,  5, 4'h0, 4'h0, 4'h0);
    add("tie8_rise",    0, 4'h0, 4'h0, 4'h0,  1, 4'h0, 4'h1, 4'h0);
    add("tie8_hold",    0, 4'h0, 4'h0, 4'h0,  5, 4'h0, 4'h1, 4'h0);
    add("tie8_fall",    0, 4'h0, 4'h0, 4'h0,  1, 4'h0, 4'h0, 4'h0);
    add("pre_rst_s1",   0, 4'h8, 4'h0, 4'h0,  6, 4'h8, 4'h0, 4'h0);
    add("pre_rst_s5",   0, 4'h8, 4'h1, 4'h0,  8, 4'h8, 4'h0, 4'h0);
    add("mid_rst",      1, 4'h8, 4'h1, 4'h0,  1, 4'h0, 4'h0, 4'h0);
    add("post_rst_a",   0, 4'h8, 4'h1, 4'h0,  1, 4'h0, 4'h0, 4'h0);
    add("post_rst_b",   0, 4'h8, 4'h0, 4'h0,  4, 4'h0, 4'h0, 4'h0);
    add("post_rst_s1",  0, 4'h8, 4'h0, 4'h0,  1, 4'h8, 4'h0, 4'h0);
    add("post_rst_s5",  0, 4'h0, 4'h0, 4'h0, 14, 4'h0, 4'h0, 4'h0);
`ifdef STUCK_DETECT_EN
    add("stk_m1",       0, 4'hC, 4'h0, 4'h8, 37, 4'hC, 4'h0, 4'h0);
    add("stk_set",      0, 4'hC, 4'h0, 4'h8,  1, 4'hC, 4'h0, 4'h8);
    add("stk_hold",     0, 4'h0, 4'h0, 4'h8, 20, 4'h8, 4'h0, 4'h8);
    add("stk_rst",      1, 4'h0, 4'h0, 4'h0,  1, 4'h0, 4'h0, 4'h0);
    add("stk_after",    0, 4'h0, 4'h0, 4'h0,  3, 4'h0, 4'h0, 4'h0);
`else
    add("nostk_hold",   0, 4'hC, 4'h0, 4'h8, 40, 4'hC, 4'h0, 4'h0);
    add("nostk_fall_m1",0, 4'h0, 4'h0, 4'h8,  5, 4'hC, 4'h0, 4'h0);
    add("nostk_fall",   0, 4'h0, 4'h0, 4'h8,  1, 4'h0, 4'h0, 4'h0);
`endif

    foreach (vq[i]) begin
      drive(vq[i].rst, vq[i].d1, vq[i].d5, vq[i].lt);
      step(vq[i].n);
      chk({vq[i].name, ".s1"},    w_s1,           vq[i].s1);
      chk({vq[i].name, ".s5"},    w_s5,           vq[i].s5);
      chk({vq[i].name, ".stuck"}, sif.stuck_flag, vq[i].st);
    end

    // NS2 dips low long enough to enter CLEARING, then returns before the clear dwell ends.
    drive(1'b1, 4'h0, 4'h0, 4'h0);
    step(2);
    drive(1'b0, 4'h0, 4'h4, 4'h0);
    step(14);
    chk("dip.pre", w_s5, 4'h4);
    drive(1'b0, 4'h0, 4'h0, 4'h0);
    step(4);
    drive(1'b0, 4'h0, 4'h4, 4'h0);
    for (int k = 0; k < 24; k++) begin
      chk($sformatf("dip.hold%0d", k), w_s5, 4'h4);
      step(1);
    end
    drive(1'b0, 4'h0, 4'h0, 4'h0);
    step(11);
    chk("dip.fall_m1", w_s5, 4'h4);
    step(1);
    chk("dip.fall", w_s5, 4'h0);

    // EW2 debounced low on the exact cycle the congestion dwell would complete.
    drive(1'b1, 4'h0, 4'h0, 4'h0);
    step(2);
    drive(1'b0, 4'h0, 4'h1, 4'h0);
    step(7);
    chk("tie7.high", w_s5, 4'h0);
    drive(1'b0, 4'h0, 4'h0, 4'h0);
    for (int k = 0; k < 15; k++) begin
      step(1);
      chk($sformatf("tie7.low%0d", k), w_s5, 4'h0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
